// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
// Contents:
//   REG_ADDR_W, DATA_W, NUM_REGS   register-file geometry
//   wb_src_e                       which producer a result came from
//   wb_entry_t                     one queued writeback (dest, data, src)
package wb_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 8;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LD  = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
    wb_src_e               src;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of pending register writebacks.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the queue)
//   push, push_entry  enqueue one entry (ignored when full)
//   pop               dequeue the head (ignored when empty)
//   head              entry at the front of the queue
//   full, empty       occupancy flags, derived from count
//   count             number of stored entries, 0..DEPTH
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap freely; occupancy comes only from count.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side controller for the 8x16 register file. Arbitrates ALU and load
// results round-robin into an in-order queue, retires one registered write
// per cycle, and tracks per-register pending writes so decode can stall.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   alu_valid/dest/data, alu_ready     ALU result channel
//   ld_valid/dest/data, ld_ready       load result channel
//   issue_valid, issue_dest            decode announces a future write
//   issue_stall                        pending counter of issue_dest saturated
//   busy                               per-register "write outstanding"
//   reg_write_en/dest/data             registered register-file write port
//   sb_err                             sticky: retire with no pending write
// Build option: define WB_ZERO_REG_EN to hardwire r0 to zero (writes to r0
// are accepted and dropped, issues to r0 are not counted).
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PEND_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_dest,
  input  logic [DATA_W-1:0]     ld_data,
  output logic                  ld_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  output logic                  issue_stall,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0]     reg_write_data,
  output logic                  sb_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_src_e             rr_last;
  wb_entry_t           push_entry;
  wb_entry_t           head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                both_valid;
  logic                ld_wins;
  logic                alu_fire;
  logic                ld_fire;
  logic                push;
  logic                pop;
  logic [PEND_W-1:0]   cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                unused_fifo;

  // Readiness ignores a same-cycle pop; on a conflict only the channel that
  // was not granted last sees ready.
  assign both_valid = alu_valid && ld_valid;
  assign ld_wins    = (rr_last == WB_SRC_ALU);
  assign alu_ready  = !fifo_full && !(both_valid && ld_wins);
  assign ld_ready   = !fifo_full && !(both_valid && !ld_wins);
  assign alu_fire   = alu_valid && alu_ready;
  assign ld_fire    = ld_valid && ld_ready;

  always_comb begin
    push_entry.dest = alu_dest;
    push_entry.data = alu_data;
    push_entry.src  = WB_SRC_ALU;
    if (ld_fire) begin
      push_entry.dest = ld_dest;
      push_entry.data = ld_data;
      push_entry.src  = WB_SRC_LD;
    end
  end

`ifdef WB_ZERO_REG_EN
  // Handshake to r0 completes but the result is dropped.
  assign push = (alu_fire || ld_fire) && (push_entry.dest != '0);
`else
  assign push = alu_fire || ld_fire;
`endif
  assign pop = !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign unused_fifo = ^{head.src, fifo_count};

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= WB_SRC_ALU;
    end else if (ld_fire) begin
      rr_last <= WB_SRC_LD;
    end else if (alu_fire) begin
      rr_last <= WB_SRC_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
    end else begin
      reg_write_en <= pop;
      if (pop) begin
        reg_write_dest <= head.dest;
        reg_write_data <= head.data;
      end
    end
  end

  assign issue_stall = (cnt[issue_dest] == {PEND_W{1'b1}});

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_valid && !issue_stall) inc_vec[issue_dest] = 1'b1;
    if (reg_write_en) dec_vec[reg_write_dest] = 1'b1;
`ifdef WB_ZERO_REG_EN
    inc_vec[0] = 1'b0;
`endif
  end

  // Simultaneous issue and retire on one register cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          if (cnt[i] == '0) sb_err <= 1'b1;
          else              cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_REGS; i++) busy[i] = (cnt[i] != '0);
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: a driver holds offers until its own model
// predicts acceptance and records the expected writes; a monitor consumes
// them as the DUT retires writes.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [2:0]  alu_dest = '0;
  logic [15:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_dest = '0;
  logic [15:0] ld_data = '0;
  logic        ld_ready;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_dest = '0;
  logic        issue_stall;
  logic [7:0]  busy;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic        sb_err;

  regfile_writeback #(.DEPTH(4), .PEND_W(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data), .ld_ready(ld_ready),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_stall(issue_stall),
    .busy(busy), .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  dest;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: outstanding writes per register, sticky error,
  // and which channel won the last grant.
  int   m_cnt [8];
  bit   m_err = 1'b0;
  bit   m_last_ld = 1'b0;

  bit          a_pend = 1'b0;
  bit          l_pend = 1'b0;
  logic [2:0]  a_dest, l_dest;
  logic [15:0] a_data, l_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic offer_alu(input logic [2:0] d, input logic [15:0] v);
    a_pend = 1'b1; a_dest = d; a_data = v;
  endtask

  task automatic offer_ld(input logic [2:0] d, input logic [15:0] v);
    l_pend = 1'b1; l_dest = d; l_data = v;
  endtask

  task automatic accept(input logic [2:0] d, input logic [15:0] v);
    exp_t e;
    bit   keep;
    keep = 1'b1;
`ifdef WB_ZERO_REG_EN
    if (d == 3'd0) keep = 1'b0;
`endif
    if (keep) begin
      e.dest = d; e.data = v; e.due = cyc + 2;
      exp_q.push_back(e);
      pend_q.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    a_pend = 1'b0; l_pend = 1'b0;
    alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pend_q.delete();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 1'b0;
    m_last_ld = 1'b0;
  endtask

  // One clock cycle: drive, predict, compare at negedge, advance the model.
  task automatic cycle(input bit iv, input logic [2:0] idest);
    bit         both, exp_ar, exp_lr, a_acc, l_acc, exp_stall, inc_ok;
    logic [7:0] exp_busy, inc_v, dec_v;
    exp_t       e;
    alu_valid = a_pend; alu_dest = a_dest; alu_data = a_data;
    ld_valid = l_pend;  ld_dest = l_dest;  ld_data = l_data;
    issue_valid = iv;   issue_dest = idest;
    both   = a_pend && l_pend;
    exp_ar = !(both && !m_last_ld);
    exp_lr = !(both && m_last_ld);
    a_acc  = a_pend && exp_ar;
    l_acc  = l_pend && exp_lr;
    exp_stall = (m_cnt[idest] == 3);
    inc_ok = iv && !exp_stall;
`ifdef WB_ZERO_REG_EN
    if (idest == 3'd0) inc_ok = 1'b0;
`endif
    for (int i = 0; i < 8; i++) exp_busy[i] = (m_cnt[i] != 0);
    @(negedge clk);
    chk("alu_ready", alu_ready, exp_ar);
    chk("ld_ready", ld_ready, exp_lr);
    chk("issue_stall", issue_stall, exp_stall);
    chk("busy", busy, exp_busy);
    chk("sb_err", sb_err, m_err);
    if (l_acc) begin
      accept(l_dest, l_data); m_last_ld = 1'b1; l_pend = 1'b0;
    end else if (a_acc) begin
      accept(a_dest, a_data); m_last_ld = 1'b0; a_pend = 1'b0;
    end
    inc_v = '0; dec_v = '0;
    if (inc_ok) inc_v[idest] = 1'b1;
    while (pend_q.size() != 0 && pend_q[0].due == cyc) begin
      e = pend_q.pop_front();
      dec_v[e.dest] = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      if (inc_v[i] && !dec_v[i]) m_cnt[i]++;
      else if (dec_v[i] && !inc_v[i]) begin
        if (m_cnt[i] == 0) m_err = 1'b1;
        else m_cnt[i]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 3'd0);
  endtask

  // Monitor: every non-reset cycle either the next expected write is due now
  // and must appear with the right dest/data, or the write strobe must be low.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          chk("wr_en", reg_write_en, 1'b1);
          chk("wr_dest", reg_write_dest, e.dest);
          chk("wr_data", reg_write_data, e.data);
        end else begin
          chk("wr_en_idle", reg_write_en, 1'b0);
        end
      end
    end
  end

  initial begin
    do_reset(2);
    idle(5);

    // single write: issue r3, then ALU pushes r3=BEEF
    cycle(1'b1, 3'd3);
    offer_alu(3'd3, 16'hBEEF);
    idle(5);

    // conflict: both channels valid for 4 cycles
    for (int i = 0; i < 4; i++) begin
      if (!a_pend) offer_alu(3'd1, 16'(16'h0001 + i));
      if (!l_pend) offer_ld(3'd2, 16'(16'h0100 + i));
      cycle(1'b0, 3'd0);
    end
    idle(5);

    // flood both channels continuously
    for (int i = 0; i < 20; i++) begin
      if (!a_pend) offer_alu(3'($urandom_range(0, 7)), 16'($urandom));
      if (!l_pend) offer_ld(3'($urandom_range(0, 7)), 16'($urandom));
      cycle(1'b1, 3'($urandom_range(0, 7)));
    end
    idle(5);

    // saturation on r5, then retire one
    do_reset(1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'd5);
    offer_alu(3'd5, 16'h5555);
    for (int i = 0; i < 5; i++) cycle(1'b0, 3'd5);

    // retire with nothing pending sets the sticky error
    offer_ld(3'd7, 16'h7777);
    idle(6);

    // reset with writes in flight
    offer_alu(3'd1, 16'h1111);
    offer_ld(3'd2, 16'h2222);
    cycle(1'b1, 3'd1);
    cycle(1'b1, 3'd2);
    offer_alu(3'd4, 16'h4444);
    cycle(1'b1, 3'd4);
    do_reset(1);
    idle(6);

    // write to r0
    offer_alu(3'd0, 16'hFFFF);
    cycle(1'b1, 3'd0);
    idle(5);

    // randomized traffic
    repeat (300) begin
      if (!a_pend && $urandom_range(0, 1) == 1) offer_alu(3'($urandom_range(0, 7)), 16'($urandom));
      if (!l_pend && $urandom_range(0, 2) == 0) offer_ld(3'($urandom_range(0, 7)), 16'($urandom));
      cycle($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
    end
    idle(6);
    chk("drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
